// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480 raster constants and timing-recovery state encoding
package vga_pkg;

    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_ACT   = 640;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_ACT   = 480;
    localparam int VGA_V_TOTAL = 525;

    localparam logic [10:0] H_CNT_MAX = 11'd2047;
    localparam logic [10:0] V_CNT_MAX = 11'd1023;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CHECK,
        ST_LOCKED
    } vga_state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] value, input logic [10:0] limit);
        return (value == limit) ? value : value + 11'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - input register and falling-edge detect for one active-low sync line
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic fall
);

    logic sync_q;
    logic sync_prev;

    // History resets high so a sync line already low after reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_prev <= sync_q;
            sync_q    <= sync;
        end
    end

    assign fall = sync_prev & ~sync_q;

endmodule

// File: rtl/vga_rx_timing.sv
// rtl/vga_rx_timing.sv - VGA sink timing recovery: raster measurement, lock and pixel coordinates
module vga_rx_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int H_ACT       = VGA_H_ACT,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int V_ACT       = VGA_V_ACT,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] rgb_r,
    input  logic [7:0] rgb_g,
    input  logic [7:0] rgb_b,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       sof,
    output logic       locked,
    output logic       err
);

    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_ACT);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_ACT);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    logic        hs_fall, vs_fall;
    logic [7:0]  r_q, g_q, b_q;
    logic [10:0] h_cnt, v_cnt, h_next, v_next, h_off, v_off;
    logic        frame_pend;
    logic [3:0]  good_cnt, good_next;
    vga_state_t  state, state_next;
    logic        line_start, frame_start, mismatch, in_win, valid_next;

    vga_sync_edge u_hs_edge (.clk(clk), .rst(rst), .sync(hsync), .fall(hs_fall));
    vga_sync_edge u_vs_edge (.clk(clk), .rst(rst), .sync(vsync), .fall(vs_fall));

    // h_next/v_next are the raster position of the sample currently in the input register;
    // h_cnt/v_cnt therefore hold the position of the previous sample when checks run.
    always_comb begin
        line_start  = hs_fall;
        frame_start = hs_fall && (frame_pend || vs_fall);
        h_next      = line_start ? 11'd0 : sat_inc(h_cnt, H_CNT_MAX);
        if (frame_start)     v_next = 11'd0;
        else if (line_start) v_next = sat_inc(v_cnt, V_CNT_MAX);
        else                 v_next = v_cnt;

        mismatch = (line_start && (h_cnt != H_LAST))
                || (frame_start && (v_cnt != V_LAST))
                || (h_cnt == H_CNT_MAX) || (v_cnt == V_CNT_MAX);

        state_next = state;
        good_next  = good_cnt;
        case (state)
            ST_SEARCH: if (frame_start) begin
                state_next = ST_CHECK;
                good_next  = 4'd0;
            end
            ST_CHECK: if (mismatch) begin
                state_next = ST_SEARCH;
            end else if (frame_start) begin
                if (good_cnt + 4'd1 >= LOCK_N) state_next = ST_LOCKED;
                else                           good_next  = good_cnt + 4'd1;
            end
            ST_LOCKED: if (mismatch) state_next = ST_SEARCH;
            default:   state_next = ST_SEARCH;
        endcase

        h_off      = h_next - H_START;
        v_off      = v_next - V_START;
        in_win     = (h_next >= H_START) && (h_next < H_END) && (v_next >= V_START) && (v_next < V_END);
        valid_next = (state_next == ST_LOCKED) && in_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            b_q        <= 8'd0;
            h_cnt      <= 11'd0;
            v_cnt      <= 11'd0;
            frame_pend <= 1'b0;
            good_cnt   <= 4'd0;
            state      <= ST_SEARCH;
            pix_valid  <= 1'b0;
            pix_x      <= 10'd0;
            pix_y      <= 10'd0;
            pix_r      <= 8'd0;
            pix_g      <= 8'd0;
            pix_b      <= 8'd0;
            sof        <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_q        <= rgb_r;
            g_q        <= rgb_g;
            b_q        <= rgb_b;
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            frame_pend <= line_start ? 1'b0 : (frame_pend | vs_fall);
            good_cnt   <= good_next;
            state      <= state_next;
            locked     <= (state_next == ST_LOCKED);
            err        <= (state != ST_SEARCH) && mismatch;
            pix_valid  <= valid_next;
            sof        <= valid_next && (h_next == H_START) && (v_next == V_START);
            if (valid_next) begin
                pix_x <= h_off[9:0];
                pix_y <= v_off[9:0];
                pix_r <= r_q;
                pix_g <= g_q;
                pix_b <= b_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_timing.sv
// tb/tb_vga_rx_timing.sv - directed bench for vga_rx_timing on a reduced 20x10 raster
module tb_vga_rx_timing;

    localparam int T_HS  = 4;
    localparam int T_HB  = 4;
    localparam int T_HA  = 8;
    localparam int T_HT  = 20;
    localparam int T_VS  = 2;
    localparam int T_VB  = 2;
    localparam int T_VA  = 4;
    localparam int T_VT  = 10;
    localparam int HSB   = T_HS + T_HB;
    localparam int VSB   = T_VS + T_VB;
    localparam int NPIX  = T_HA * T_VA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [7:0] rgb_r = 8'd0, rgb_g = 8'd0, rgb_b = 8'd0;
    logic       pix_valid, sof, locked, err;
    logic [9:0] pix_x, pix_y;
    logic [7:0] pix_r, pix_g, pix_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int frame_cyc = 0;
    int line_cyc = 0;

    int vcnt = 0, data_bad = 0, sof_cnt = 0, sof_bad = 0, err_cnt = 0, lk_cnt = 0;
    int last_sof_cyc = -1, last_err_cyc = -1, last_lock_cyc = -1, last_unlock_cyc = -1;
    logic locked_d = 1'b0;

    vga_rx_timing #(
        .H_SYNC(T_HS), .H_BACK(T_HB), .H_ACT(T_HA), .H_TOTAL(T_HT),
        .V_SYNC(T_VS), .V_BACK(T_VB), .V_ACT(T_VA), .V_TOTAL(T_VT),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .sof(sof), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel data encodes its true raster position, so output data must match output coordinates.
    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            vcnt = vcnt + 1;
            if (pix_r !== pix_x[7:0] || pix_g !== pix_y[7:0] || pix_b !== (8'hA5 ^ pix_x[7:0]))
                data_bad = data_bad + 1;
        end
        if (sof === 1'b1) begin
            sof_cnt = sof_cnt + 1;
            last_sof_cyc = cyc;
            if (pix_valid !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) sof_bad = sof_bad + 1;
        end
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (locked === 1'b1) lk_cnt = lk_cnt + 1;
        if (locked === 1'b1 && locked_d !== 1'b1) last_lock_cyc = cyc;
        if (locked !== 1'b1 && locked_d === 1'b1) last_unlock_cyc = cyc;
        locked_d = locked;
    end

    task automatic drive_cycle(input int ln, input int c, input int nlines, input bit early_vs);
        @(negedge clk);
        if (c == 0) begin
            line_cyc = cyc;
            if (ln == 0) frame_cyc = cyc;
        end
        hsync = (c >= T_HS);
        vsync = !((ln < T_VS) || (early_vs && ln == nlines - 1 && c >= 10));
        rgb_r = 8'(c - HSB);
        rgb_g = 8'(ln - VSB);
        rgb_b = 8'hA5 ^ 8'(c - HSB);
    endtask

    task automatic drive_frame(input int nlines, input int long_line, input bit early_vs);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int c = 0; c < ((ln == long_line) ? T_HT + 1 : T_HT); c++)
                drive_cycle(ln, c, nlines, early_vs);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        tests_run++; if (pix_x !== 10'd0) begin tests_failed++; $display("FAIL reset_pix_x: got %0d expected 0", pix_x); end
        tests_run++; if (pix_y !== 10'd0) begin tests_failed++; $display("FAIL reset_pix_y: got %0d expected 0", pix_y); end
        tests_run++; if ({pix_r, pix_g, pix_b} !== 24'd0) begin tests_failed++; $display("FAIL reset_rgb: got %h expected 0", {pix_r, pix_g, pix_b}); end
        tests_run++; if (sof !== 1'b0) begin tests_failed++; $display("FAIL reset_sof: got %b expected 0", sof); end
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL reset_locked: got %b expected 0", locked); end
        tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_lock;
        int e0, s0, v0;
        e0 = err_cnt; s0 = sof_cnt; v0 = vcnt;
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL lock_early: got %b expected 0 after two frames", locked); end
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL lock_state: got %b expected 1", locked); end
        tests_run++; if (last_lock_cyc !== frame_cyc + 2) begin tests_failed++; $display("FAIL lock_time: got %0d expected %0d", last_lock_cyc, frame_cyc + 2); end
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL lock_err: got %0d pulses expected 0", err_cnt - e0); end
        tests_run++; if (sof_cnt - s0 !== 1) begin tests_failed++; $display("FAIL lock_sof_count: got %0d expected 1", sof_cnt - s0); end
        tests_run++; if (last_sof_cyc !== frame_cyc + VSB * T_HT + HSB + 2) begin tests_failed++; $display("FAIL lock_sof_time: got %0d expected %0d", last_sof_cyc, frame_cyc + VSB * T_HT + HSB + 2); end
        tests_run++; if (vcnt - v0 !== NPIX) begin tests_failed++; $display("FAIL lock_valid_count: got %0d expected %0d", vcnt - v0, NPIX); end
    endtask

    task automatic test_stream;
        int e0, s0, v0;
        e0 = err_cnt; s0 = sof_cnt; v0 = vcnt;
        drive_frame(T_VT, -1, 1'b1);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (vcnt - v0 !== 2 * NPIX) begin tests_failed++; $display("FAIL stream_valid_count: got %0d expected %0d", vcnt - v0, 2 * NPIX); end
        tests_run++; if (sof_cnt - s0 !== 2) begin tests_failed++; $display("FAIL stream_sof_count: got %0d expected 2", sof_cnt - s0); end
        tests_run++; if (last_sof_cyc !== frame_cyc + VSB * T_HT + HSB + 2) begin tests_failed++; $display("FAIL stream_sof_time: got %0d expected %0d", last_sof_cyc, frame_cyc + VSB * T_HT + HSB + 2); end
        tests_run++; if (err_cnt - e0 !== 0) begin tests_failed++; $display("FAIL stream_err: got %0d expected 0", err_cnt - e0); end
        tests_run++; if (data_bad !== 0 || sof_bad !== 0) begin tests_failed++; $display("FAIL stream_data: got %0d bad pixels %0d bad sof expected 0", data_bad, sof_bad); end
        tests_run++; if (pix_valid !== 1'b0 || pix_x !== 10'(T_HA - 1) || pix_y !== 10'(T_VA - 1)) begin tests_failed++; $display("FAIL stream_hold: got v=%b x=%0d y=%0d expected v=0 x=%0d y=%0d", pix_valid, pix_x, pix_y, T_HA - 1, T_VA - 1); end
    endtask

    task automatic test_long_line;
        int e0, v0, fc;
        e0 = err_cnt;
        drive_frame(T_VT, 3, 1'b0);
        fc = frame_cyc;
        tests_run++; if (last_err_cyc !== fc + 3 * T_HT + T_HT + 1 + 2) begin tests_failed++; $display("FAIL long_err_time: got %0d expected %0d", last_err_cyc, fc + 3 * T_HT + T_HT + 3); end
        tests_run++; if (last_unlock_cyc !== last_err_cyc) begin tests_failed++; $display("FAIL long_unlock_time: got %0d expected %0d", last_unlock_cyc, last_err_cyc); end
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL long_relock_early: got %b expected 0", locked); end
        v0 = vcnt;
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL long_relock: got %b expected 1", locked); end
        tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL long_err_count: got %0d expected 1", err_cnt - e0); end
        tests_run++; if (vcnt - v0 !== NPIX) begin tests_failed++; $display("FAIL long_valid_count: got %0d expected %0d", vcnt - v0, NPIX); end
    endtask

    task automatic test_check_fail;
        int e0, l0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        e0 = err_cnt; l0 = lk_cnt;
        drive_frame(T_VT - 1, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (last_err_cyc !== frame_cyc + 2) begin tests_failed++; $display("FAIL short_err_time: got %0d expected %0d", last_err_cyc, frame_cyc + 2); end
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL short_err_count: got %0d expected 1", err_cnt - e0); end
        tests_run++; if (lk_cnt - l0 !== 0 || locked !== 1'b0) begin tests_failed++; $display("FAIL short_locked: got %0d locked cycles expected 0", lk_cnt - l0); end
    endtask

    task automatic test_hsync_stuck;
        int e0, s;
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL stuck_prelock: got %b expected 1", locked); end
        s = line_cyc;
        e0 = err_cnt;
        idle(2100);
        tests_run++; if (err_cnt - e0 !== 1) begin tests_failed++; $display("FAIL stuck_err_count: got %0d expected 1", err_cnt - e0); end
        tests_run++; if (last_err_cyc !== s + 2050) begin tests_failed++; $display("FAIL stuck_err_time: got %0d expected %0d", last_err_cyc, s + 2050); end
        tests_run++; if (locked !== 1'b0 || last_unlock_cyc !== last_err_cyc) begin tests_failed++; $display("FAIL stuck_unlock: got locked=%b at %0d expected 0 at %0d", locked, last_unlock_cyc, last_err_cyc); end
    endtask

    task automatic test_reset_mid_frame;
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        for (int ln = 0; ln < 5; ln++)
            for (int c = 0; c < T_HT; c++) drive_cycle(ln, c, T_VT, 1'b0);
        for (int c = 0; c < 12; c++) drive_cycle(5, c, T_VT, 1'b0);
        tests_run++; if (pix_valid !== 1'b1 || pix_x !== 10'd1 || pix_y !== 10'd1) begin tests_failed++; $display("FAIL mid_pre: got v=%b x=%0d y=%0d expected v=1 x=1 y=1", pix_valid, pix_x, pix_y); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if ({pix_valid, sof, locked, err} !== 4'b0 || pix_x !== 10'd0 || pix_y !== 10'd0 || {pix_r, pix_g, pix_b} !== 24'd0) begin tests_failed++; $display("FAIL mid_reset: got v=%b s=%b l=%b e=%b x=%0d y=%0d rgb=%h expected all 0", pix_valid, sof, locked, err, pix_x, pix_y, {pix_r, pix_g, pix_b}); end
        rst = 1'b0;
        idle(3);
        drive_frame(T_VT, -1, 1'b0);
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL mid_relock_early: got %b expected 0", locked); end
        drive_frame(T_VT, -1, 1'b0);
        tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL mid_relock: got %b expected 1", locked); end
        tests_run++; if (data_bad !== 0 || sof_bad !== 0) begin tests_failed++; $display("FAIL final_data: got %0d bad pixels %0d bad sof expected 0", data_bad, sof_bad); end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_stream;
        test_long_line;
        test_check_fail;
        test_hsync_stuck;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_rx_timing.md
# vga_rx_timing

Sink-side VGA timing recovery block: samples an incoming active-low hsync/vsync pair and 8-bit RGB on the pixel clock, measures line and frame length, and declares lock once consecutive frames match the expected 640x480 / 800x525 raster. When locked, it emits per-pixel coordinates, data-valid and start-of-frame, so frame capture and test-pattern checkers can consume the output of the VGA pattern generator without any extra signals beyond its pins.

## Interface
- H_SYNC, 96, hsync low width in clocks (informational; not checked)
- H_BACK, 48, clocks from hsync fall to first active pixel minus H_SYNC
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, clocks per line
- V_SYNC, 2, vsync low width in lines (informational)
- V_BACK, 33, lines from vsync fall to first active line minus V_SYNC
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)
- clk  in  1  pixel clock; sole clock domain
- rst  in  1  synchronous, active-high reset
- hsync  in  1  active-low horizontal sync
- vsync  in  1  active-low vertical sync
- rgb_r / rgb_g / rgb_b  in  8 each  pixel data
- pix_valid  out  1  active pixel present on pix_* this cycle
- pix_x  out  10  active column 0..H_ACT-1
- pix_y  out  10  active row 0..V_ACT-1
- pix_r / pix_g / pix_b  out  8 each  registered pixel data
- sof  out  1  one-cycle pulse, coincident with pix_valid at (0,0)
- locked  out  1  raster lock status
- err  out  1  one-cycle pulse on any timing mismatch while in CHECK or LOCKED

## Operation
- Stage 1: all inputs registered once (hs_q, vs_q, rgb_q); previous hs_q/vs_q kept for edge detect.
- Line start: hs_q==0 and hs_q_prev==1. That cycle h_cnt <= 0; otherwise h_cnt increments, saturating at 2047 (11 bits).
- Frame-pending flag set on vs_q falling edge; cleared on the next line start. At line start: v_cnt <= 0 if flag set (or vsync falls the same cycle), else v_cnt+1, saturating at 1023 (10 bits... use 11 bits internally).
- Line check at each line start (except the first after leaving SEARCH): h_cnt must equal H_TOTAL-1.
- Frame check at each frame start (v_cnt reset): previous v_cnt must equal V_TOTAL-1.
- FSM states SEARCH, CHECK, LOCKED:
  - SEARCH: counters run, no checks; on first frame start -> CHECK, good_cnt=0.
  - CHECK: line or frame mismatch -> err, SEARCH. Passing frame check increments good_cnt; reaching LOCK_FRAMES -> LOCKED.
  - LOCKED: any mismatch -> err, locked deasserts, SEARCH. Saturation of h_cnt or v_cnt counts as mismatch immediately.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACT), v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACT). pix_x = h_cnt-(H_SYNC+H_BACK), pix_y = v_cnt-(V_SYNC+V_BACK), 10-bit truncation.
- pix_valid asserts only in LOCKED and inside the window; pix_* data hold last value when invalid.

## Timing
- Reset: pix_valid=0, pix_x=0, pix_y=0, pix_r/g/b=0, sof=0, locked=0, err=0; FSM=SEARCH, counters 0, edge-detect history =1 (sync idle high).
- Latency: pin sample to pix_* output = 2 clocks (input reg + output reg); pix_r/g/b aligned with pix_x/pix_y/pix_valid.
- Pixel at pin clock edge N with hsync fall at edge F: pix_x = N-F-(H_SYNC+H_BACK).
- locked rises the cycle after the LOCK_FRAMES-th passing frame check; first pix_valid is the next active pixel.
- err and locked fall in the same cycle as the detected mismatch appears at output stage.
- Reset mid-frame: all state cleared next edge; relock needs a full frame start plus LOCK_FRAMES frames.
- Simultaneous hsync and vsync fall: treated as frame start and line start in one cycle.

## Structure
- Shared package vga_pkg: 640x480 timing constants (H_*/V_* defaults) and the FSM state enumeration; the generator and this block both import it.
- One sub-module, vga_sync_edge: input register plus falling-edge detect for one sync line, instantiated for hsync and vsync.

## Test plan
- Reset then drive compliant 800x525 raster (hsync low 96 clk, vsync low 2 lines) for 3 frames -> locked=1 after frame 2 check, no err, first sof at frame 3 pixel (0,0).
- Locked raster with rgb = pix_x[7:0] pattern -> every pix_valid cycle pix_r equals pix_x[7:0]; exactly 307200 pix_valid per frame.
- Insert one 801-clock line while locked -> err pulse once, locked=0 same cycle, relock after 2 further good frames.
- Frame of 524 lines during CHECK -> err, return to SEARCH, locked stays 0.
- Hold hsync high 2100 clocks -> h_cnt saturates, err pulse, locked=0.
- Assert rst mid-frame while locked -> next cycle all outputs 0, locked=0; resume raster -> locked after 2 good frames.
